// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE,
    ABORT,
    DRAIN
  } state_t;

  // Master chip-selects are active low; all ones means no slave selected.
  localparam logic [3:0] SLV_IDLE_CS = 4'hF;
  localparam int         NREQ_DEF    = 4;
  localparam int         IDX_W       = $clog2(NREQ_DEF);

  // Binary slave index to the master's one-hot select.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational rotate-priority arbiter: the first set request at or above
// ptr (wrapping) wins, so ptr-1 has the lowest priority.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    vld,
  output logic [$clog2(NREQ)-1:0] win
);

  localparam int AW = $clog2(NREQ);

  int k;

  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    vld = 1'b0;
    win = '0;
    k   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (req[k]) begin
        vld = 1'b1;
        win = AW'(k);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master between NREQ requesters: round-robin grant, frame and
// slave latch, start/done handshake, per-requester ack or timeout error.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DW      = 12,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 511
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ*2-1:0]       req_slave,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] active_id,
  output logic                    spi_start,
  output logic [DW-1:0]           spi_din,
  output logic [NSLV-1:0]         spi_which_slave,
  input  logic [NSLV-1:0]         spi_cs,
  input  logic                    spi_done
);

  localparam int AW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   ptr, win, ptr_inc;
  logic            win_vld, grant;
  logic            done_q, done_rise, cs_idle, tmo;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] id_oh;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (req),
    .ptr (ptr),
    .vld (win_vld),
    .win (win)
  );

  assign cs_idle   = (spi_cs == SLV_IDLE_CS);
  assign done_rise = spi_done & ~done_q;
  // The counter reaches TIMEOUT on the edge where it currently holds TIMEOUT-1.
  assign tmo       = (cnt == CW'(TIMEOUT - 1));
  // Only grant into a master that is genuinely idle (covers post-reset recovery).
  assign grant     = win_vld & cs_idle & ~spi_done;
  assign ptr_inc   = (active_id == AW'(NREQ - 1)) ? '0 : active_id + 1'b1;
  assign id_oh     = {{(NREQ-1){1'b0}}, 1'b1} << active_id;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; done beats timeout in WAIT, timeout beats accept in LAUNCH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = LAUNCH;
      LAUNCH:  if (tmo) state_nxt = ABORT;
               else if (!cs_idle) state_nxt = WAIT;
      WAIT:    if (done_rise) state_nxt = DONE;
               else if (tmo) state_nxt = ABORT;
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = DRAIN;
      DRAIN:   if (cs_idle && !spi_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from state; ack and err live in disjoint states.
  always_comb begin
    busy      = (state != IDLE);
    spi_start = (state == LAUNCH);
    ack       = (state == DONE)  ? id_oh : '0;
    err       = (state == ABORT) ? id_oh : '0;
  end

  // Grant latch, timeout counter, edge detect and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q          <= 1'b0;
      cnt             <= '0;
      ptr             <= '0;
      active_id       <= '0;
      spi_din         <= '0;
      spi_which_slave <= '0;
    end else begin
      done_q <= spi_done;
      if (state == IDLE && grant) begin
        spi_din         <= req_data[win*DW +: DW];
        spi_which_slave <= onehot4(req_slave[win*2 +: 2]);
        active_id       <= win;
        cnt             <= '0;
      end else if (state == LAUNCH || state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (state == DONE || state == ABORT) ptr <= ptr_inc;
    end
  end

endmodule
